// File: rtl/conv_col_writer.sv
// rtl/conv_col_writer.sv - writes one conv output column as two packed FP16 memory words
// A column is captured in IDLE, then emitted as a low word (rows 0..15) and a high word (remaining rows).
module conv_col_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_SIZE   = 24,
  parameter int WORD_LANES = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0,
  parameter int APPLY_RELU = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           col_valid,
  output logic                           col_ready,
  input  logic [5:0]                     col_num,
  input  logic [OUT_SIZE*DATA_WIDTH-1:0] col_data,
  output logic                           mem_we,
  input  logic                           mem_ready,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [WORD_LANES*DATA_WIDTH-1:0] mem_wdata,
  output logic [5:0]                     cols_written,
  output logic                           frame_done,
  output logic                           err_col
);

  localparam int COL_W  = OUT_SIZE * DATA_WIDTH;
  localparam int WORD_W = WORD_LANES * DATA_WIDTH;
  localparam int PAD_W  = 2 * WORD_W - COL_W;
  localparam logic [5:0] LP_OUT = 6'(OUT_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_WR_LO, S_WR_HI} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [5:0]            r_col;
  logic [COL_W-1:0]      r_data;
  logic [5:0]            r_cols;
  logic                  r_frame_done;
  logic                  r_err;
  logic                  r_stale;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_done;
  logic [COL_W-1:0]      w_relu_data;
  logic [2*WORD_W-1:0]   w_rows_pad;
  logic [ADDR_WIDTH-1:0] w_addr_base;

  assign w_accept    = col_valid && col_ready;
  assign w_in_range  = {1'b0, col_num} < 7'(OUT_SIZE);
  assign w_done      = (r_state == S_WR_HI) && mem_ready;
  assign w_rows_pad  = {{PAD_W{1'b0}}, r_data};
  assign w_addr_base = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({r_col, 1'b0});

  always_comb begin
    w_relu_data = col_data;
    if (APPLY_RELU != 0) begin
      for (int r = 0; r < OUT_SIZE; r++) begin
        if (col_data[r*DATA_WIDTH + DATA_WIDTH - 1]) begin
          w_relu_data[r*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_in_range) w_next_state = S_WR_LO;
      S_WR_LO: if (mem_ready) w_next_state = S_WR_HI;
      S_WR_HI: if (mem_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    col_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        col_ready = 1'b1;
      end
      S_WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = w_addr_base;
        mem_wdata = w_rows_pad[0 +: WORD_W];
      end
      S_WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = w_addr_base + ADDR_WIDTH'(1);
        mem_wdata = w_rows_pad[WORD_W +: WORD_W];
      end
      default: begin
        col_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_data <= '0;
    end else if (w_accept && w_in_range) begin
      r_col  <= col_num;
      r_data <= w_relu_data;
    end
  end

  // r_stale marks a write that began before the latest frame_start; it completes but is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cols       <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_stale      <= 1'b0;
    end else begin
      r_frame_done <= w_done && !frame_start && !r_stale && (r_cols == LP_OUT - 6'd1);
      if (frame_start) begin
        r_cols <= '0;
      end else if (w_done && !r_stale && (r_cols != LP_OUT)) begin
        r_cols <= r_cols + 6'd1;
      end
      if (w_accept && !w_in_range) begin
        r_err <= 1'b1;
      end else if (frame_start) begin
        r_err <= 1'b0;
      end
      if (w_accept && w_in_range) begin
        r_stale <= 1'b0;
      end else if (frame_start && (r_state != S_IDLE)) begin
        r_stale <= 1'b1;
      end
    end
  end

  assign cols_written = r_cols;
  assign frame_done   = r_frame_done;
  assign err_col      = r_err;

endmodule

// File: tb/tb_conv_col_writer.sv
// tb/tb_conv_col_writer.sv - scoreboard bench for conv_col_writer (plain and ReLU instances)
module tb_conv_col_writer;
  localparam int DW = 16;
  localparam int OS = 24;
  localparam int AW = 12;
  localparam int CW = OS * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_start = 1'b0;
  logic col_valid = 1'b0;
  logic mem_ready = 1'b0;
  logic [5:0] col_num = '0;
  logic [CW-1:0] col_data = '0;

  logic col_ready0, mem_we0, frame_done0, err_col0;
  logic [AW-1:0] mem_addr0;
  logic [255:0] mem_wdata0;
  logic [5:0] cols_written0;
  logic col_ready1, mem_we1, frame_done1, err_col1;
  logic [AW-1:0] mem_addr1;
  logic [255:0] mem_wdata1;
  logic [5:0] cols_written1;

  conv_col_writer #(.APPLY_RELU(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .col_valid(col_valid),
    .col_ready(col_ready0), .col_num(col_num), .col_data(col_data), .mem_we(mem_we0),
    .mem_ready(mem_ready), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cols_written(cols_written0), .frame_done(frame_done0), .err_col(err_col0));

  conv_col_writer #(.APPLY_RELU(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .col_valid(col_valid),
    .col_ready(col_ready1), .col_num(col_num), .col_data(col_data), .mem_we(mem_we1),
    .mem_ready(mem_ready), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cols_written(cols_written1), .frame_done(frame_done1), .err_col(err_col1));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [255:0]  data;
    int            fid;
    bit            hi;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0;
  int cyc = 0, fid = 0, exp_cols = 0, exp_fd = 0, fd_seen = 0;
  int hs_count = 0, last_hs_cyc = -10, last_acc = 0;
  bit exp_err = 0;
  bit rand_ready = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected memory word: rows split 16 per word, ReLU zeroes negative FP16 values.
  function automatic logic [255:0] word_of(input logic [CW-1:0] d, input bit relu, input bit hi);
    logic [255:0] w;
    logic [15:0] v;
    w = '0;
    for (int r = 0; r < OS; r++) begin
      v = d[r*16 +: 16];
      if (relu && v[15]) v = 16'h0000;
      if (!hi && r < 16) w[r*16 +: 16] = v;
      else if (hi && r >= 16) w[(r-16)*16 +: 16] = v;
    end
    return w;
  endfunction

  function automatic logic [CW-1:0] rand_col();
    logic [CW-1:0] d;
    for (int r = 0; r < OS; r++) d[r*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_we0 && mem_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual_addr=%0h required=none", mem_addr0);
      end else begin
        e0 = q0.pop_front();
        chk("wr_addr", mem_addr0, e0.addr);
        chk("wr_data", mem_wdata0, e0.data);
        hs_count++;
        last_hs_cyc = cyc;
        if (e0.hi && e0.fid == fid && exp_cols < OS) begin
          exp_cols++;
          if (exp_cols == OS) exp_fd++;
        end
      end
    end
    if (rst_n && mem_we1 && mem_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write_relu actual_addr=%0h required=none", mem_addr1);
      end else begin
        e1 = q1.pop_front();
        chk("relu_wr_addr", mem_addr1, e1.addr);
        chk("relu_wr_data", mem_wdata1, e1.data);
      end
    end
    if (frame_done0) begin
      fd_seen++;
      chk("frame_done_timing", cyc, last_hs_cyc + 1);
    end
  end

  task automatic push_col(input int col, input logic [CW-1:0] d);
    exp_t e;
    for (int h = 0; h < 2; h++) begin
      e.addr = AW'(2 * col + h);
      e.fid = fid;
      e.hi = (h == 1);
      e.data = word_of(d, 1'b0, e.hi);
      q0.push_back(e);
      e.data = word_of(d, 1'b1, e.hi);
      q1.push_back(e);
    end
  endtask

  task automatic send(input int col, input logic [CW-1:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    col_valid = 1'b1;
    col_num = 6'(col);
    col_data = d;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = col_ready0;
      if (ok) begin
        last_acc = cyc;
        if (col < OS) push_col(col, d);
        else exp_err = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    col_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout col=%0d required=accept", col);
    end
  endtask

  task automatic fs();
    frame_start = 1'b1;
    fid++;
    exp_cols = 0;
    exp_err = 0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !col_ready0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout pending=%0d required=0", q0.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] d;
    int t0, hs_before, col;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_mem_wdata", mem_wdata0, 0);
    chk("rst_cols", cols_written0, 0);
    chk("rst_frame_done", frame_done0, 0);
    chk("rst_err", err_col0, 0);
    chk("rst_col_ready", col_ready0, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    mem_ready = 1'b1;
    fs();
    for (int r = 0; r < OS; r++) d[r*16 +: 16] = 16'h3C00 + 16'(r);
    send(3, d);
    wait_idle();
    chk("col3_cols", cols_written0, exp_cols);
    chk("col3_cols_one", cols_written0, 1);

    fs();
    for (int c = 0; c < OS; c++) begin
      send(c, rand_col());
      if (c == 0) t0 = last_acc;
    end
    chk("throughput", last_acc - t0, 3 * (OS - 1));
    wait_idle();
    chk("full_cols", cols_written0, exp_cols);
    chk("full_fd_count", fd_seen, exp_fd);
    chk("full_fd_once", fd_seen, 1);

    send(5, rand_col());
    send(5, rand_col());
    wait_idle();
    chk("sat_cols", cols_written0, OS);
    chk("sat_fd_count", fd_seen, exp_fd);

    fs();
    send(4, rand_col());
    send(4, rand_col());
    wait_idle();
    chk("dup_cols", cols_written0, exp_cols);

    fs();
    mem_ready = 1'b0;
    hs_before = hs_count;
    d = rand_col();
    send(7, d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_we", mem_we0, 1);
      chk("stall_addr", mem_addr0, 14);
      chk("stall_data", mem_wdata0, word_of(d, 1'b0, 1'b0));
      chk("stall_col_ready", col_ready0, 0);
    end
    chk("stall_no_write", hs_count, hs_before);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_idle();
    chk("stall_writes", hs_count, hs_before + 2);

    hs_before = hs_count;
    send(30, rand_col());
    wait_idle();
    chk("badcol_err", err_col0, exp_err);
    chk("badcol_no_write", hs_count, hs_before);
    fs();
    chk("badcol_err_clr", err_col0, 0);

    d = rand_col();
    d[15:0] = 16'hBC00;
    d[31:16] = 16'h3C00;
    send(0, d);
    wait_idle();

    fs();
    send(9, rand_col());
    fs();
    wait_idle();
    chk("inflight_uncounted", cols_written0, exp_cols);

    fs();
    for (int c = 0; c < OS - 1; c++) send(c, rand_col());
    send(OS - 1, rand_col());
    @(posedge clk); #1;
    fs();
    wait_idle();
    chk("coincide_cols", cols_written0, 0);
    chk("coincide_no_fd", fd_seen, exp_fd);

    fs();
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      col = $urandom_range(0, 27);
      send(col, rand_col());
      if ($urandom_range(0, 14) == 0) fs();
    end
    wait_idle();
    rand_ready = 0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    chk("rand_cols", cols_written0, exp_cols);
    chk("rand_fd", fd_seen, exp_fd);
    chk("rand_err", err_col0, exp_err);

    fs();
    send(5, rand_col());
    wait_idle();
    mem_ready = 1'b0;
    send(6, rand_col());
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_hi_we", mem_we0, 0);
    chk("rst_hi_addr", mem_addr0, 0);
    chk("rst_hi_data", mem_wdata0, 0);
    chk("rst_hi_cols", cols_written0, 0);
    q0.delete();
    q1.delete();
    fid++;
    exp_cols = 0;
    exp_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    send(2, rand_col());
    wait_idle();
    chk("post_rst_cols", cols_written0, exp_cols);
    chk("post_rst_cols_one", cols_written0, 1);

    chk("queues_drained", q0.size() + q1.size(), 0);
    chk("final_fd", fd_seen, exp_fd);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
